pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter register and next-PC sequencer for the MIPS fetch stage.
//  Consumes the shifted branch offset and the formed jump target and picks the next fetch address.
//  Arbitrates jump-register, jump, branch and sequential flow. Handles stall.
//  Optionally implements the architectural branch delay slot.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  PC_STEP       4              sequential increment, in bytes
// PORTS
//  Clk           in   1   clock; all state changes on the rising edge
//  Reset         in   1   asynchronous, active-high reset
//  Stall         in   1   1 = hold PC; redirects are captured, not applied
//  Branch        in   1   taken conditional branch for the instruction at PC
//  BranchOffset  in   32  sign-extended word offset, already shifted left by 2
//  Jump          in   1   J/JAL for the instruction at PC
//  JumpTarget    in   32  formed target {PCPlus4[31:28], instr_index, 2'b00}
//  JumpReg       in   1   JR/JALR for the instruction at PC
//  RegTarget     in   32  rs register value for JR/JALR
//  PC            out  32  current fetch address (registered)
//  PCPlus4       out  32  PC + PC_STEP (combinational, modulo 2^32)
//  Redirected    out  1   1-cycle pulse after the PC loads a non-sequential target
//  AddrErr       out  1   1-cycle pulse: the applied target had bits [1:0] != 0
// BEHAVIOUR
//  - Reset, asynchronous and active-high:
//    - PC=RESET_VECTOR; Redirected=0; AddrErr=0; pending register cleared; state=RUN.
//    - Asserting Reset mid-operation discards any pending or slot target.
//  - Target selection, combinational, in priority order:
//    - JumpReg: RegTarget.
//    - Jump: JumpTarget.
//    - Branch: PCPlus4 + BranchOffset (32-bit add, wraps; no overflow flag).
//    - Otherwise: none, sequential flow.
//  - Applied target = {tgt[31:2],2'b00}. AddrErr pulses in the cycle after the load when tgt[1:0]!=0.
//  - States:
//    - RUN: no redirect waiting.
//    - HOLD: redirect captured during Stall.
//    - SLOT: delay slot; exists only with the macro enabled.
//  - RUN, Stall=0:
//    - With a redirect, PC <= target, latency 1 edge, Redirected=1 next cycle.
//    - With no redirect, PC <= PCPlus4.
//  - RUN, Stall=1:
//    - PC holds.
//    - A redirect is stored in the pending register; state moves to HOLD.
//  - HOLD, Stall=1:
//    - PC holds.
//    - A new redirect overwrites pending (the newest wins).
//  - HOLD, Stall=0:
//    - PC <= pending target; state returns to RUN.
//    - Redirect inputs in this cycle are ignored; pending has priority.
//  - Multiple redirect inputs asserted together: the priority above applies; no error is raised.
//  - Sequential wrap: PC=32'hFFFF_FFFC -> 32'h0000_0000.
// CONFIGURATION
//  BRANCH_DELAY_SLOT_EN defined:
//    - An applied redirect in RUN loads PC <= PCPlus4 (the delay-slot instruction).
//    - The target is stored and state moves to SLOT.
//    - At the next Stall=0 edge, PC <= stored target and Redirected pulses.
//    - Redirect inputs in SLOT are ignored.
//    - Leaving HOLD also goes through SLOT.
//    - Stall in SLOT holds both PC and the stored target.
//  BRANCH_DELAY_SLOT_EN undefined:
//    - No SLOT state; redirects apply directly as described above.
// TESTING
//  - Reset, no redirects, 3 edges -> PC = 0x0, 0x4, 0x8, 0xC; Redirected=0.
//  - PC=0x100, Branch=1, BranchOffset=0xFFFF_FFF0:
//    - Without macro -> next PC=0xF4, Redirected=1.
//    - With macro -> PC 0x104, then 0xF4.
//  - PC=0x200, JumpReg=1, RegTarget=0x3002, Jump=1, JumpTarget=0x400 -> PC=0x3000, AddrErr=1.
//  - Stall=1 with Jump to 0x800, then Branch (offset 0x10) while still stalled:
//    - Stall released -> PC=PC_at_branch+4+0x10; the Jump is discarded.
//  - PC=0xFFFF_FFFC, sequential -> PC=0x0.
//  - Reset asserted mid-operation with a pending (HOLD) or slot (SLOT) target -> PC=RESET_VECTOR immediately.
//    - After release, sequential fetch resumes; no Redirected pulse.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter register and next-PC sequencer for the MIPS fetch stage.
// Optional delay-slot behaviour is enabled by defining BRANCH_DELAY_SLOT_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_STEP      = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Branch,
  input  logic [31:0] BranchOffset,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        JumpReg,
  input  logic [31:0] RegTarget,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Redirected,
  output logic        AddrErr
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1
`ifdef BRANCH_DELAY_SLOT_EN
    ,SLOT = 2'd2
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;   // pending (HOLD) or delay-slot (SLOT) target, unaligned
  logic        redir_q, redir_d;
  logic        aerr_q, aerr_d;
  logic [31:0] tgt;
  logic        redir;

  assign PCPlus4    = pc_q + 32'(PC_STEP);
  assign PC         = pc_q;
  assign Redirected = redir_q;
  assign AddrErr    = aerr_q;

  always_comb begin
    tgt = 32'h0;
    if (JumpReg)     tgt = RegTarget;
    else if (Jump)   tgt = JumpTarget;
    else if (Branch) tgt = PCPlus4 + BranchOffset;
  end

  assign redir = JumpReg | Jump | Branch;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    redir_d = 1'b0;
    aerr_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (Stall) begin
          if (redir) begin
            tgt_d   = tgt;
            state_d = HOLD;
          end
        end else if (redir) begin
`ifdef BRANCH_DELAY_SLOT_EN
          pc_d    = PCPlus4;
          tgt_d   = tgt;
          state_d = SLOT;
`else
          pc_d    = {tgt[31:2], 2'b00};
          redir_d = 1'b1;
          aerr_d  = |tgt[1:0];
`endif
        end else begin
          pc_d = PCPlus4;
        end
      end
      HOLD: begin
        // Newest redirect wins while stalled; on release, inputs are ignored.
        if (Stall) begin
          if (redir) tgt_d = tgt;
        end else begin
`ifdef BRANCH_DELAY_SLOT_EN
          pc_d    = PCPlus4;
          state_d = SLOT;
`else
          pc_d    = {tgt_q[31:2], 2'b00};
          redir_d = 1'b1;
          aerr_d  = |tgt_q[1:0];
          state_d = RUN;
`endif
        end
      end
`ifdef BRANCH_DELAY_SLOT_EN
      SLOT: begin
        if (!Stall) begin
          pc_d    = {tgt_q[31:2], 2'b00};
          redir_d = 1'b1;
          aerr_d  = |tgt_q[1:0];
          state_d = RUN;
        end
      end
`endif
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      tgt_q   <= 32'h0;
      redir_q <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      redir_q <= redir_d;
      aerr_q  <= aerr_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expectations follow BRANCH_DELAY_SLOT_EN.
module tb_pc_sequencer;
  logic        Clk = 1'b0;
  logic        Reset, Stall, Branch, Jump, JumpReg;
  logic [31:0] BranchOffset, JumpTarget, RegTarget;
  logic [31:0] PC, PCPlus4;
  logic        Redirected, AddrErr;
  int          tests = 0;
  int          fails = 0;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Branch(Branch),
    .BranchOffset(BranchOffset), .Jump(Jump), .JumpTarget(JumpTarget),
    .JumpReg(JumpReg), .RegTarget(RegTarget), .PC(PC), .PCPlus4(PCPlus4),
    .Redirected(Redirected), .AddrErr(AddrErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Jump-register to addr and let any delay slot drain.
  task automatic goto_pc(input logic [31:0] addr);
    JumpReg = 1'b1; RegTarget = addr;
    step();
    JumpReg = 1'b0;
    if (DS) step();
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Branch = 1'b0; Jump = 1'b0; JumpReg = 1'b0;
    BranchOffset = 32'h0; JumpTarget = 32'h0; RegTarget = 32'h0;
    step();
    chk("rst_pc", PC, 32'h0);
    chk("rst_redir", {31'h0, Redirected}, 32'h0);
    chk("rst_aerr", {31'h0, AddrErr}, 32'h0);
    Reset = 1'b0;
    #1;
    chk("rel_pc", PC, 32'h0);
    chk("rel_pcp4", PCPlus4, 32'h4);
    step(); chk("seq1", PC, 32'h4);
    step(); chk("seq2", PC, 32'h8);
    step(); chk("seq3", PC, 32'hC);
    chk("seq_redir", {31'h0, Redirected}, 32'h0);

    // branch backwards from 0x100
    goto_pc(32'h100);
    chk("goto100", PC, 32'h100);
    chk("goto_redir", {31'h0, Redirected}, 32'h1);
    Branch = 1'b1; BranchOffset = 32'hFFFF_FFF0;
    step();
    Branch = 1'b0;
    if (DS) begin
      chk("br_slot_pc", PC, 32'h104);
      chk("br_slot_redir", {31'h0, Redirected}, 32'h0);
      step();
    end
    chk("br_pc", PC, 32'hF4);
    chk("br_redir", {31'h0, Redirected}, 32'h1);
    chk("br_aerr", {31'h0, AddrErr}, 32'h0);
    step();
    chk("br_after_pc", PC, 32'hF8);
    chk("br_pulse_end", {31'h0, Redirected}, 32'h0);

    // JumpReg beats Jump; misaligned target
    goto_pc(32'h200);
    JumpReg = 1'b1; RegTarget = 32'h3002; Jump = 1'b1; JumpTarget = 32'h400;
    step();
    JumpReg = 1'b0; Jump = 1'b0;
    if (DS) begin
      chk("jr_slot_pc", PC, 32'h204);
      step();
    end
    chk("jr_pc", PC, 32'h3000);
    chk("jr_aerr", {31'h0, AddrErr}, 32'h1);
    chk("jr_redir", {31'h0, Redirected}, 32'h1);
    step();
    chk("jr_after_pc", PC, 32'h3004);
    chk("aerr_pulse_end", {31'h0, AddrErr}, 32'h0);

    // stall: Jump captured, then overwritten by Branch; release ignores inputs
    Stall = 1'b1; Jump = 1'b1; JumpTarget = 32'h800;
    step();
    chk("stall1_pc", PC, 32'h3004);
    Jump = 1'b0; Branch = 1'b1; BranchOffset = 32'h10;
    step();
    chk("stall2_pc", PC, 32'h3004);
    Branch = 1'b0;
    step();
    chk("stall3_pc", PC, 32'h3004);
    chk("stall_redir", {31'h0, Redirected}, 32'h0);
    Stall = 1'b0; Jump = 1'b1; JumpTarget = 32'h900;
    step();
    Jump = 1'b0;
    if (DS) begin
      chk("hold_slot_pc", PC, 32'h3008);
      step();
    end
    chk("hold_rel_pc", PC, 32'h3018);
    chk("hold_rel_redir", {31'h0, Redirected}, 32'h1);

    // sequential wrap
    goto_pc(32'hFFFF_FFFC);
    chk("wrap_pcp4", PCPlus4, 32'h0);
    step(); chk("wrap_pc", PC, 32'h0);
    step(); chk("wrap_next", PC, 32'h4);

    // reset with a pending HOLD target
    Stall = 1'b1; Jump = 1'b1; JumpTarget = 32'h500;
    step();
    Jump = 1'b0;
    chk("pend_pc", PC, 32'h4);
    Reset = 1'b1;
    #2;
    chk("rst_hold_pc", PC, 32'h0);
    Reset = 1'b0; Stall = 1'b0;
    step();
    chk("rst_hold_seq", PC, 32'h4);
    chk("rst_hold_redir", {31'h0, Redirected}, 32'h0);
    step();
    chk("rst_hold_seq2", PC, 32'h8);

    // reset right after a redirect is taken (SLOT when delay slot is on)
    Jump = 1'b1; JumpTarget = 32'h700;
    step();
    Jump = 1'b0;
    chk("pre_rst_pc", PC, DS ? 32'hC : 32'h700);
    Reset = 1'b1;
    #2;
    chk("rst_slot_pc", PC, 32'h0);
    Reset = 1'b0;
    step();
    chk("rst_slot_seq", PC, 32'h4);
    chk("rst_slot_redir", {31'h0, Redirected}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish, expected finish before 50000");
    $fatal(1, "timeout");
  end
endmodule
